// File: rtl/io_bus_pkg.sv
// Shared types and helpers for the CPU-to-peripheral I/O fabric.
// Read FSM states, unmapped read value and channel/lane helpers.
package io_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } io_rd_state_t;

  localparam logic [15:0] IO_UNMAPPED_DATA = 16'hFFFF;

  function automatic logic [15:0] byte_lane(
    input logic [15:0] data,
    input logic        sel
  );
    return {8'h00, sel ? data[15:8] : data[7:0]};
  endfunction

  function automatic logic ch_mapped(
    input int ch,
    input int n_ch
  );
    return (ch >= 1) && (ch < n_ch);
  endfunction

endpackage

// File: rtl/io_bus_read_fsm.sv
// Handshaked read path: request, wait for ack or timeout, respond.
// Owns the timer, data capture and byte-lane response formatting.
module io_bus_read_fsm
  import io_bus_pkg::*;
#(
  parameter int N_CH        = 8,
  parameter int SEL_W       = 6,
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req,
  input  logic [SEL_W-1:0]   sel,
  input  logic               byte_op,
  input  logic               lane_sel,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [N_CH-1:0]    ack,
  input  logic [16*N_CH-1:0] data_in,
  output logic [15:0]        data_out,
  output logic               valid,
  output logic               busy,
  output logic               err,
  output logic [N_CH-1:0]    rd_req,
  output logic [ADDR_W-1:0]  rd_addr
);

  localparam int CH_W = $clog2(N_CH);
  localparam int TM_W = $clog2(TIMEOUT_CYC);
  localparam logic [TM_W-1:0] TM_LAST =
    TM_W'(TIMEOUT_CYC - 1);

  io_rd_state_t state, state_n;

  logic [TM_W-1:0] timer;
  logic [CH_W-1:0] ch_q;
  logic            byte_q;
  logic            lane_q;

  logic            mapped;
  logic            accept;
  logic            load;
  logic            set_err;
  logic [15:0]     raw;
  logic            fmt_byte;
  logic            fmt_lane;
  logic [15:0]     fmt;

  logic [15:0] lane_data [N_CH];

  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    assign lane_data[c] = data_in[16*c +: 16];
  end

  assign mapped = ch_mapped(int'(sel), N_CH);
  assign valid  = (state == RESP);
  assign busy   = (state != IDLE);

  // Unmapped reads respond straight from IDLE, so format with live flags.
  assign fmt_byte = (state == IDLE) ? byte_op  : byte_q;
  assign fmt_lane = (state == IDLE) ? lane_sel : lane_q;
  assign fmt = fmt_byte ? byte_lane(raw, fmt_lane) : raw;

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    load    = 1'b0;
    set_err = 1'b0;
    raw     = IO_UNMAPPED_DATA;
    unique case (state)
      IDLE: begin
        if (req) begin
          accept  = 1'b1;
          load    = !mapped;
          state_n = mapped ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (ack[ch_q]) begin
          load    = 1'b1;
          raw     = lane_data[ch_q];
          state_n = RESP;
        end else if (timer == TM_LAST) begin
          load    = 1'b1;
          set_err = 1'b1;
          state_n = RESP;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      timer    <= '0;
      ch_q     <= '0;
      byte_q   <= 1'b0;
      lane_q   <= 1'b0;
      rd_addr  <= '0;
      rd_req   <= '0;
      data_out <= '0;
      err      <= 1'b0;
    end else begin
      state  <= state_n;
      rd_req <= '0;
      if (accept) begin
        ch_q    <= sel[CH_W-1:0];
        byte_q  <= byte_op;
        lane_q  <= lane_sel;
        rd_addr <= addr;
        timer   <= '0;
        err     <= 1'b0;
        if (mapped) begin
          rd_req <= N_CH'(1) << sel;
        end
      end else if (state == WAIT) begin
        timer <= timer + 1'b1;
      end
      if (load) begin
        data_out <= fmt;
      end
      if (set_err) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_bus_fabric.sv
// CPU I/O port to N_CH peripheral channels: posted writes with
// byte enables plus a handshaked, timeout-guarded read path.
module io_bus_fabric
  import io_bus_pkg::*;
#(
  parameter int N_CH        = 8,
  parameter int SEL_LSB     = 26,
  parameter int SEL_W       = 6,
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic               main_clk,
  input  logic               main_rst_n,
  input  logic [31:0]        address_out_io,
  input  logic [15:0]        data_in_io,
  input  logic [1:0]         control_out_io,
  input  logic               io_read_req,
  output logic [15:0]        data_out_io,
  output logic               io_read_valid,
  output logic               io_busy,
  output logic               err_timeout,
  output logic [N_CH-1:0]    wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [15:0]        wr_data,
  output logic [1:0]         wr_be,
  output logic [N_CH-1:0]    rd_req,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [N_CH-1:0]    rd_ack,
  input  logic [16*N_CH-1:0] rd_data
);

  logic [SEL_W-1:0] ch;
  logic             wr_hit;
  logic             unused_addr;

  assign ch     = address_out_io[SEL_LSB +: SEL_W];
  assign wr_hit = control_out_io[1] && ch_mapped(int'(ch), N_CH);

  // Address bits between the word address and the select field are don't-care.
  assign unused_addr = ^address_out_io;

  always_ff @(posedge main_clk) begin
    if (!main_rst_n) begin
      wr_en   <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_be   <= '0;
    end else begin
      wr_en <= '0;
      if (wr_hit) begin
        wr_en   <= N_CH'(1) << ch;
        wr_addr <= address_out_io[ADDR_W:1];
        if (control_out_io[0]) begin
          wr_data <= {2{data_in_io[7:0]}};
          wr_be   <= address_out_io[0] ? 2'b10 : 2'b01;
        end else begin
          wr_data <= data_in_io;
          wr_be   <= 2'b11;
        end
      end
    end
  end

  io_bus_read_fsm #(
    .N_CH        (N_CH),
    .SEL_W       (SEL_W),
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rd (
    .clk      (main_clk),
    .rst_n    (main_rst_n),
    .req      (io_read_req),
    .sel      (ch),
    .byte_op  (control_out_io[0]),
    .lane_sel (address_out_io[0]),
    .addr     (address_out_io[ADDR_W:1]),
    .ack      (rd_ack),
    .data_in  (rd_data),
    .data_out (data_out_io),
    .valid    (io_read_valid),
    .busy     (io_busy),
    .err      (err_timeout),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr)
  );

endmodule

// File: tb/tb_io_bus_fabric.sv
// Directed and randomized bench for io_bus_fabric with a
// latency/value reference model of the read and write paths.
module tb_io_bus_fabric;

  localparam int T = 64;

  logic         main_clk = 1'b0;
  logic         main_rst_n;
  logic [31:0]  address_out_io;
  logic [15:0]  data_in_io;
  logic [1:0]   control_out_io;
  logic         io_read_req;
  logic [15:0]  data_out_io;
  logic         io_read_valid;
  logic         io_busy;
  logic         err_timeout;
  logic [7:0]   wr_en;
  logic [15:0]  wr_addr;
  logic [15:0]  wr_data;
  logic [1:0]   wr_be;
  logic [7:0]   rd_req;
  logic [15:0]  rd_addr;
  logic [7:0]   rd_ack;
  logic [127:0] rd_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 main_clk = ~main_clk;

  io_bus_fabric dut (
    .main_clk       (main_clk),
    .main_rst_n     (main_rst_n),
    .address_out_io (address_out_io),
    .data_in_io     (data_in_io),
    .control_out_io (control_out_io),
    .io_read_req    (io_read_req),
    .data_out_io    (data_out_io),
    .io_read_valid  (io_read_valid),
    .io_busy        (io_busy),
    .err_timeout    (err_timeout),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_be          (wr_be),
    .rd_req         (rd_req),
    .rd_addr        (rd_addr),
    .rd_ack         (rd_ack),
    .rd_data        (rd_data)
  );

  task automatic step();
    @(posedge main_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dout"},  32'(data_out_io),   0);
    chk({tag, "_valid"}, 32'(io_read_valid), 0);
    chk({tag, "_busy"},  32'(io_busy),       0);
    chk({tag, "_err"},   32'(err_timeout),   0);
    chk({tag, "_wren"},  32'(wr_en),         0);
    chk({tag, "_waddr"}, 32'(wr_addr),       0);
    chk({tag, "_wdata"}, 32'(wr_data),       0);
    chk({tag, "_wbe"},   32'(wr_be),         0);
    chk({tag, "_rdreq"}, 32'(rd_req),        0);
    chk({tag, "_raddr"}, 32'(rd_addr),       0);
  endtask

  function automatic bit m_mapped(input int ch);
    return ch >= 1 && ch < 8;
  endfunction

  function automatic logic [7:0] m_en(input logic [31:0] a);
    int ch;
    ch = int'(a[31:26]);
    return m_mapped(ch) ? 8'(1 << ch) : 8'h00;
  endfunction

  function automatic logic [15:0] m_wdata(input logic [15:0] d,
                                          input bit bop);
    return bop ? {d[7:0], d[7:0]} : d;
  endfunction

  function automatic logic [1:0] m_wbe(input logic [31:0] a,
                                       input bit bop);
    if (!bop) return 2'b11;
    return a[0] ? 2'b10 : 2'b01;
  endfunction

  task automatic chk_write(input string tag, input logic [31:0] a,
                           input logic [15:0] d, input bit bop);
    chk({tag, "_wren"}, 32'(wr_en), 32'(m_en(a)));
    if (m_en(a) != 8'h00) begin
      chk({tag, "_waddr"}, 32'(wr_addr), 32'(a[16:1]));
      chk({tag, "_wdata"}, 32'(wr_data), 32'(m_wdata(d, bop)));
      chk({tag, "_wbe"},   32'(wr_be),   32'(m_wbe(a, bop)));
    end
  endtask

  // d = WAIT-cycle index at which the peripheral starts acking.
  task automatic do_read(input string tag, input int ch, input bit bop,
                         input bit odd, input logic [15:0] val,
                         input int d, input bit poke, input bit wr);
    logic [31:0] a;
    logic [15:0] rawv, exp_d, wd;
    logic [7:0]  ackbit, noise;
    bit          mapped;
    int          lat, n, got, extra, busy_n;
    a = (32'(ch) << 26) | (32'($urandom_range(0, 16'hFFFF)) << 1)
        | 32'(odd);
    mapped = m_mapped(ch);
    rawv   = (mapped && d <= T - 1) ? val : 16'hFFFF;
    exp_d  = bop ? {8'h00, odd ? rawv[15:8] : rawv[7:0]} : rawv;
    lat    = !mapped ? 1 : (d <= T - 1 ? d + 2 : T + 1);
    ackbit = mapped ? 8'(1 << ch) : 8'h00;
    wd     = 16'($urandom);
    rd_data = {$urandom, $urandom, $urandom, $urandom};
    if (mapped) rd_data[16*ch +: 16] = val;
    address_out_io = a;
    data_in_io     = wd;
    control_out_io = {wr, bop};
    io_read_req    = 1'b1;
    rd_ack         = 8'h00;
    step();
    io_read_req    = 1'b0;
    control_out_io = 2'b00;
    if (wr) chk_write({tag, "_rw"}, a, wd, bop);
    got = 0; extra = 0; busy_n = 0;
    for (n = 1; n <= T + 8; n++) begin
      if (n == 1) begin
        chk({tag, "_rdreq"}, 32'(rd_req), 32'(ackbit));
        chk({tag, "_errclr"}, 32'(err_timeout), 0);
        if (mapped) chk({tag, "_raddr"}, 32'(rd_addr), 32'(a[16:1]));
      end else if (rd_req != 8'h00) begin
        extra++;
      end
      if (io_busy) busy_n++;
      if (io_read_valid) begin
        got = n;
        break;
      end
      if (poke && n == 2) begin
        io_read_req    = 1'b1;
        address_out_io = 32'h1C00_0000;
      end else begin
        io_read_req = 1'b0;
      end
      noise = 8'($urandom) & ~ackbit;
      if (mapped && n >= d + 1) noise = noise | ackbit;
      rd_ack = noise;
      step();
    end
    io_read_req = 1'b0;
    rd_ack      = 8'h00;
    chk({tag, "_lat"}, 32'(got), 32'(lat));
    chk({tag, "_data"}, 32'(data_out_io), 32'(exp_d));
    chk({tag, "_err"}, 32'(err_timeout), 32'(mapped && d > T - 1));
    chk({tag, "_extra"}, 32'(extra), 0);
    chk({tag, "_busyn"}, 32'(busy_n), 32'(lat));
    step();
    chk({tag, "_vdone"}, 32'(io_read_valid), 0);
    chk({tag, "_bdone"}, 32'(io_busy), 0);
    chk({tag, "_hold"}, 32'(data_out_io), 32'(exp_d));
  endtask

  initial begin
    logic [31:0] a;
    logic [15:0] d;
    bit          bop;
    int          ch, dl;

    main_rst_n     = 1'b0;
    address_out_io = '0;
    data_in_io     = '0;
    control_out_io = 2'b00;
    io_read_req    = 1'b0;
    rd_ack         = '0;
    rd_data        = '0;
    step();
    step();
    chk_zero("reset");
    main_rst_n = 1'b1;
    step();

    // Word write to ch1
    address_out_io = 32'h0400_0010;
    data_in_io     = 16'h0ABC;
    control_out_io = 2'b10;
    step();
    control_out_io = 2'b00;
    chk("w1_en",   32'(wr_en),   32'h02);
    chk("w1_addr", 32'(wr_addr), 32'h0008);
    chk("w1_data", 32'(wr_data), 32'h0ABC);
    chk("w1_be",   32'(wr_be),   32'h3);
    step();
    chk("w1_drop", 32'(wr_en), 0);

    // Byte write, odd address, ch2
    address_out_io = 32'h0800_0003;
    data_in_io     = 16'h1234;
    control_out_io = 2'b11;
    step();
    chk("w2_en",   32'(wr_en),   32'h04);
    chk("w2_data", 32'(wr_data), 32'h3434);
    chk("w2_be",   32'(wr_be),   32'h2);

    // Unmapped writes: ch0 then ch9 back to back
    address_out_io = 32'h0000_0010;
    control_out_io = 2'b10;
    step();
    chk("w_ch0", 32'(wr_en), 0);
    address_out_io = 32'h2400_0010;
    step();
    chk("w_ch9", 32'(wr_en), 0);
    control_out_io = 2'b00;
    step();

    // Zero-wait reads on ch3, word then odd byte
    do_read("r3w", 3, 1'b0, 1'b0, 16'hBEEF, 0, 1'b0, 1'b0);
    do_read("r3b", 3, 1'b1, 1'b1, 16'hBEEF, 0, 1'b0, 1'b0);

    // Timeout on ch4, late ack ignored, next read clears err
    do_read("r4to", 4, 1'b0, 1'b0, 16'h1111, 1000, 1'b0, 1'b0);
    rd_ack = 8'h10;
    step();
    chk("late_valid", 32'(io_read_valid), 0);
    chk("late_err",   32'(err_timeout),   1);
    rd_ack = 8'h00;
    do_read("r5", 5, 1'b0, 1'b0, 16'h5A5A, 2, 1'b0, 1'b0);

    // Timeout on a byte read gives 0x00FF
    do_read("r4tob", 4, 1'b1, 1'b1, 16'h2222, 1000, 1'b0, 1'b0);

    // Unmapped channel and read-while-busy
    do_read("r3f", 63, 1'b0, 1'b0, 16'h0000, 0, 1'b0, 1'b0);
    do_read("r0b", 0, 1'b1, 1'b0, 16'h0000, 0, 1'b0, 1'b0);
    do_read("rpoke", 6, 1'b0, 1'b0, 16'hC0DE, 5, 1'b1, 1'b0);

    // Read and write in the same cycle
    do_read("rw", 7, 1'b1, 1'b0, 16'h7E57, 1, 1'b0, 1'b1);

    // Reset in WAIT with an ack pending
    address_out_io = 32'h0800_0000;
    io_read_req    = 1'b1;
    step();
    io_read_req = 1'b0;
    rd_ack      = 8'h04;
    main_rst_n  = 1'b0;
    step();
    chk_zero("rst_mid");
    main_rst_n = 1'b1;
    step();
    chk("rst_mid_v", 32'(io_read_valid), 0);
    chk("rst_mid_b", 32'(io_busy), 0);
    rd_ack = 8'h00;
    do_read("r_after", 2, 1'b0, 1'b0, 16'hA55A, 3, 1'b0, 1'b0);

    // Random back-to-back writes
    for (int i = 0; i < 24; i++) begin
      a   = {6'($urandom_range(0, 9)), 26'($urandom)};
      d   = 16'($urandom);
      bop = 1'($urandom);
      address_out_io = a;
      data_in_io     = d;
      control_out_io = {1'b1, bop};
      step();
      chk_write($sformatf("rw%0d", i), a, d, bop);
    end
    control_out_io = 2'b00;
    step();
    chk("rw_idle", 32'(wr_en), 0);

    // Random reads
    for (int i = 0; i < 30; i++) begin
      ch = ($urandom_range(0, 9) == 0) ? int'($urandom_range(8, 63))
                                       : int'($urandom_range(0, 7));
      dl = ($urandom_range(0, 9) == 0) ? 1000
                                       : int'($urandom_range(0, 6));
      do_read($sformatf("rr%0d", i), ch, 1'($urandom), 1'($urandom),
              16'($urandom), dl, 1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/io_bus_fabric.md
Name: io_bus_fabric

Overview:
- Parametrised CPU-to-peripheral I/O fabric. Generalises the fixed single-channel write decode into N_CH decoded channels.
- Adds posted writes with byte enables and a handshaked read path with per-transaction timeout.
- Sits between the CPU I/O port (address_out_io/data_in_io/control_out_io/data_out_io) and the peripherals (VGA, future UART/timer). Channel = address[SEL_LSB+SEL_W-1:SEL_LSB].

Parameters:
- N_CH, 8: number of decoded channels. Channel 0 is reserved/unmapped; channels >= N_CH are unmapped.
- SEL_LSB, 26: LSB of the channel-select field in address_out_io.
- SEL_W, 6: width of the channel-select field.
- ADDR_W, 16: peripheral word-address width, taken from address_out_io[ADDR_W:1].
- TIMEOUT_CYC, 64: maximum WAIT cycles before a read aborts (>=2).

Ports:
- main_clk  in  1  single clock.
- main_rst_n  in  1  synchronous active-low reset.
- address_out_io  in  32  CPU byte address.
- data_in_io  in  16  CPU write data.
- control_out_io  in  2  {do_partial_write_instant, do_byte_operation_instant}; bit1 = write strobe, bit0 = byte op.
- io_read_req  in  1  CPU read strobe, one cycle.
- data_out_io  out  16  read data; valid while io_read_valid.
- io_read_valid  out  1  one-cycle read-completion pulse.
- io_busy  out  1  read in flight.
- err_timeout  out  1  last read timed out; sticky until the next accepted read.
- wr_en  out  N_CH  one-hot write strobe.
- wr_addr  out  ADDR_W  shared word address.
- wr_data  out  16  shared write data.
- wr_be  out  2  byte enables {hi, lo}.
- rd_req  out  N_CH  one-hot read request pulse.
- rd_addr  out  ADDR_W  read word address, held for the whole transaction.
- rd_ack  in  N_CH  per-channel read acknowledge.
- rd_data  in  16*N_CH  per-channel read data; channel c at [16c+15:16c].

Behaviour:
- Reset (main_rst_n=0 at an edge): state IDLE. All outputs 0, including data_out_io, err_timeout, wr_*, rd_*. Reset mid-transaction abandons it; no io_read_valid is produced.
- Write path (posted, 1-cycle latency, accepted in any state):
  - A write is requested when control_out_io[1]=1.
  - Next cycle: wr_en[ch]=1 only if 1<=ch<N_CH. Unmapped writes are dropped silently.
  - wr_addr = address[ADDR_W:1].
  - Byte op: wr_data = {d[7:0], d[7:0]}; wr_be = address[0] ? 2'b10 : 2'b01.
  - Word op: wr_data = d; wr_be = 2'b11.
  - All wr_* are registered. wr_en deasserts the following cycle unless a new write arrives. Back-to-back writes are supported every cycle.
- Read FSM, IDLE -> WAIT -> RESP -> IDLE:
  - IDLE with io_read_req=1: latch ch, byte flag, address[0], and rd_addr.
    - Mapped ch: go to WAIT; rd_req[ch]=1 for exactly the first WAIT cycle.
    - Unmapped ch: go to RESP with data 16'hFFFF and err_timeout=0.
  - WAIT: io_busy=1. Timer counts from 0.
    - rd_ack[ch] sampled 1 (including during the rd_req cycle): capture rd_data[ch] and go to RESP.
    - Timer reaches TIMEOUT_CYC-1 without ack: capture 16'hFFFF, set err_timeout=1, go to RESP.
    - Ack and timeout on the same edge: ack wins.
  - RESP: io_read_valid=1 for one cycle and data_out_io is driven, then IDLE. io_busy=1 in RESP.
    - Byte op: data_out_io = {8'h00, lane}, where lane = address[0] ? hi : lo. The timeout/unmapped value becomes 16'h00FF.
    - data_out_io holds its value until the next completion.
  - io_read_req while io_busy=1: ignored; the CPU must wait for !io_busy.
  - err_timeout clears when a read is accepted in IDLE.
- rd_ack on any non-selected channel, or any ack while in IDLE: ignored.
- Latency: zero-wait peripheral: req edge 0, rd_req cycle 1, io_read_valid cycle 2. Unmapped: valid cycle 1.
- A read and a write in the same cycle are both accepted independently.
- Timer width: $clog2(TIMEOUT_CYC). It resets to 0 on entry to WAIT.

Decomposition:
- Package io_bus_pkg:
  - State enum io_rd_state_t {IDLE, WAIT, RESP}.
  - Constant IO_UNMAPPED_DATA = 16'hFFFF.
  - Function byte_lane(data, sel) returning {8'h00, lane}.
  - Function ch_mapped(ch, N_CH).
- One sub-module, io_bus_read_fsm: state, timer, capture, and response formatting. The write path stays in the top level.

Test Plan:
- Word write ch1, addr 0x0400_0010, data 0x0ABC -> next cycle wr_en=8'b0000_0010, wr_addr=0x0008, wr_data=0x0ABC, wr_be=2'b11; one cycle only.
- Byte write ch2, addr 0x0800_0003, data 0x1234 -> wr_data=0x3434, wr_be=2'b10. Write to ch0 or ch9 -> wr_en stays 0.
- Read ch3, ack with 0xBEEF same cycle as rd_req -> io_read_valid at cycle 2, data_out_io=0xBEEF, err_timeout=0. Byte read at odd address -> 0x00BE.
- Read ch4, no ack -> io_busy for TIMEOUT_CYC+1 cycles, then valid with 0xFFFF and err_timeout=1. A late ack is ignored. The next read clears err_timeout.
- Read unmapped ch 0x3F -> valid at cycle 1 with 0xFFFF, no rd_req. io_read_req while busy -> no extra rd_req or valid.
- Assert main_rst_n=0 during WAIT with rd_ack pending -> all outputs 0 next cycle, no io_read_valid. A read after reset works normally.
